swi_operand_reader: RTL and testbench
=====================================

Name: swi_operand_reader

Overview:
- Input-side front end for the board's 8 slide switches. It synchronizes and debounces SWI, then captures 2-bit operands A and B into registers on a load-switch edge.
- It provides stable, registered operands and flags to downstream logic: the LED A/B display mux and the LCD debug fields.
- The display logic reads what this block writes.

Parameters:
- NBITS, 8, switch bus width
- OPW, 2, operand width
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized bit must differ from its stable value before it is accepted (>=2)

Ports:
- clk_2  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- swi  input  NBITS  raw switch inputs, asynchronous to clk_2
- swi_stable  output  NBITS  debounced switch value
- op_a  output  OPW  captured operand A
- op_b  output  OPW  captured operand B
- a_valid  output  1  op_a holds a captured value
- b_valid  output  1  op_b holds a captured value
- sel_b  output  1  debounced select, swi_stable[7]
- load_done  output  1  one-cycle pulse after each capture
- busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release): every register and output is 0, and the FSM is in IDLE.
- Field map on swi_stable:
  - [0] = load key
  - [1] = clear key (optional feature only)
  - [4:3] = A source
  - [6:5] = B source
  - [7] = select (0 = A, 1 = B)
  - [2] is unused but is still debounced.
- Synchronizer: a 2-flop chain per bit, giving sync[i].
- Debounce, per bit:
  - cnt[i] is cleared whenever sync[i] == swi_stable[i].
  - Otherwise cnt[i] increments each cycle.
  - When sync[i] != swi_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1, swi_stable[i] takes sync[i] at that edge and cnt[i] clears.
  - Latency from a raw change held steady to swi_stable change is exactly 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches swi_stable.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps because it clears on acceptance.
- Load edge: load_rise = swi_stable[0] & ~prev_load, where prev_load is registered each cycle.
- FSM states: IDLE, CAPTURE, WAIT_RELEASE.
  - IDLE: if load_rise, go to CAPTURE.
  - CAPTURE (1 cycle):
    - if sel_b=0: op_a <= swi_stable[4:3] and a_valid <= 1
    - else: op_b <= swi_stable[6:5] and b_valid <= 1
    - load_done = 1 for this cycle only
    - go to WAIT_RELEASE
  - WAIT_RELEASE: stay until swi_stable[0]==0, then go to IDLE.
- Operand values and sel_b are sampled in the CAPTURE cycle, not at the edge cycle.
- Any load_rise seen outside IDLE is ignored. One capture occurs per press/release.
- The non-selected operand and its valid flag hold their values.
- Recapture into an already-valid operand overwrites it. The valid flag stays 1.
- busy = (state != IDLE).
- Reset asserted mid-operation (any state) returns to IDLE and clears the operands and valids immediately.
- If the load switch is still high after reset release, the edge detector starts with prev_load=0 but swi_stable[0]=0 after reset. The switch must pass debounce before any capture, so exactly one capture follows.

Optional Feature:
- Macro SWI_READER_CLEAR_EN.
- Defined: a rising edge of swi_stable[1] in IDLE clears op_a, op_b, a_valid and b_valid on the next edge.
  - If clear and load edges occur in the same cycle, load wins (go to CAPTURE) and the clear is dropped.
  - Clear edges outside IDLE are ignored.
- Undefined: swi_stable[1] is debounced but has no effect, and no clear logic is synthesized.

Decomposition:
- Shared package swi_reader_pkg holds:
  - the state enum (IDLE, CAPTURE, WAIT_RELEASE)
  - localparams for the field positions (LOAD_BIT=0, CLEAR_BIT=1, A_LSB=3, B_LSB=5, SEL_BIT=7)
- One sub-module, swi_debounce: per-bit synchronizer plus counter, parameterised by DEBOUNCE_CYCLES, instantiated in a generate loop NBITS times.

Test Plan:
- Reset: assert reset with swi=8'hFF, then release -> all outputs 0. swi_stable goes to 8'hFF exactly 6 cycles after release with swi held; a capture then occurs because the load key is high.
- Debounce: toggle swi[4] high for 3 cycles, then low -> swi_stable[4] never changes. Hold high for 6 cycles -> swi_stable[4] rises on cycle 6.
- Capture A: swi=8'b0001_1000, then raise swi[0] -> after debounce, one CAPTURE cycle with op_a=2'b11, a_valid=1, load_done pulsed once, and op_b/b_valid unchanged.
- Capture B and hold: swi=8'b1100_0000, raise swi[0] and hold for 20 cycles -> op_b=2'b10, b_valid=1, a single load_done, busy=1 until swi[0] is debounced low.
- Reset mid-op: assert reset while in WAIT_RELEASE with op_a=2'b01 -> op_a=0, a_valid=0, busy=0 asynchronously.
- SWI_READER_CLEAR_EN: with a_valid=b_valid=1, raise swi[1] -> both clear. Raise swi[0] and swi[1] together -> capture occurs and valids are not cleared.

Source files
------------

// File: rtl/swi_reader_pkg.sv
// Shared definitions for the switch operand reader.
// Holds the capture FSM state encoding and the bit positions of each field
// within the debounced switch bus.
package swi_reader_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CAPTURE      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam int LOAD_BIT  = 0;
  localparam int CLEAR_BIT = 1;
  localparam int A_LSB     = 3;
  localparam int B_LSB     = 5;
  localparam int SEL_BIT   = 7;

endpackage

// File: rtl/swi_debounce.sv
// One-bit synchronizer plus debouncer.
// The raw input passes through a 2-flop synchronizer. dout only takes the
// synchronized value after it has differed from dout for DEBOUNCE_CYCLES
// consecutive cycles. Steady-state latency from raw change to dout is
// 2 + DEBOUNCE_CYCLES cycles.
// Ports:
//   clk_2  - system clock
//   reset  - asynchronous, active-high reset
//   din    - raw asynchronous input
//   dout   - debounced output
module swi_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Clearing on acceptance keeps the counter from ever wrapping.
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/swi_operand_reader.sv
// Switch operand reader: debounces the slide switches and captures 2-bit
// operands A and B on a rising edge of the debounced load key.
// Field map on swi_stable: [0] load, [1] clear, [4:3] A source,
// [6:5] B source, [7] select (0 = A, 1 = B), [2] unused.
// Optional feature macro: SWI_READER_CLEAR_EN -- a rising edge of the clear
// key while idle wipes both operands and their valid flags.
// Ports:
//   clk_2, reset         - clock, async active-high reset
//   swi                  - raw switch bus
//   swi_stable           - debounced switch bus
//   op_a, op_b           - captured operands
//   a_valid, b_valid     - operand holds a captured value
//   sel_b                - debounced select key
//   load_done            - high for the single CAPTURE cycle
//   busy                 - FSM not in IDLE
module swi_operand_reader
  import swi_reader_pkg::*;
#(
  parameter int NBITS           = 8,
  parameter int OPW             = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi,
  output logic [NBITS-1:0] swi_stable,
  output logic [OPW-1:0]   op_a,
  output logic [OPW-1:0]   op_b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             sel_b,
  output logic             load_done,
  output logic             busy
);

  state_t state;
  logic   prev_load;
  logic   load_rise;

  for (genvar i = 0; i < NBITS; i++) begin : g_db
    swi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_2 (clk_2),
      .reset (reset),
      .din   (swi[i]),
      .dout  (swi_stable[i])
    );
  end

  assign load_rise = swi_stable[LOAD_BIT] & ~prev_load;
  assign sel_b     = swi_stable[SEL_BIT];
  assign busy      = (state != IDLE);

`ifdef SWI_READER_CLEAR_EN
  logic prev_clr;
  logic clear_rise;
  assign clear_rise = swi_stable[CLEAR_BIT] & ~prev_clr;
`endif

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev_load <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      load_done <= 1'b0;
`ifdef SWI_READER_CLEAR_EN
      prev_clr  <= 1'b0;
`endif
    end else begin
      prev_load <= swi_stable[LOAD_BIT];
      load_done <= 1'b0;
`ifdef SWI_READER_CLEAR_EN
      prev_clr  <= swi_stable[CLEAR_BIT];
`endif
      case (state)
        IDLE: begin
          // load_done is raised on entry so it is high exactly while in CAPTURE
          if (load_rise) begin
            state     <= CAPTURE;
            load_done <= 1'b1;
          end
`ifdef SWI_READER_CLEAR_EN
          // Load takes priority; a simultaneous clear edge is dropped.
          else if (clear_rise) begin
            op_a    <= '0;
            op_b    <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
          end
`endif
        end
        CAPTURE: begin
          // Operands and select are sampled here, one cycle after the edge.
          if (swi_stable[SEL_BIT]) begin
            op_b    <= swi_stable[B_LSB +: OPW];
            b_valid <= 1'b1;
          end else begin
            op_a    <= swi_stable[A_LSB +: OPW];
            a_valid <= 1'b1;
          end
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!swi_stable[LOAD_BIT]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swi_operand_reader.sv
module tb_swi_operand_reader;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] swi;
  logic [7:0] swi_stable;
  logic [1:0] op_a, op_b;
  logic       a_valid, b_valid, sel_b, load_done, busy;

  typedef struct {
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic       a_valid;
    logic       b_valid;
  } cap_t;

  cap_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ld_cnt = 0;
  bit   chk_pend = 0;

  swi_operand_reader #(.NBITS(8), .OPW(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .swi        (swi),
    .swi_stable (swi_stable),
    .op_a       (op_a),
    .op_b       (op_b),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .sel_b      (sel_b),
    .load_done  (load_done),
    .busy       (busy)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_2);
    @(negedge clk_2);
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic av, input logic bv);
    cap_t c;
    c.op_a = a; c.op_b = b; c.a_valid = av; c.b_valid = bv;
    exp_q.push_back(c);
  endtask

  // Scoreboard: a load_done pulse claims the oldest expected capture; the
  // operand registers are compared one cycle later, after CAPTURE retires.
  always @(negedge clk_2) begin
    if (chk_pend) begin
      cap_t e;
      e = exp_q.pop_front();
      check("cap_op_a",    32'(op_a),    32'(e.op_a));
      check("cap_op_b",    32'(op_b),    32'(e.op_b));
      check("cap_a_valid", 32'(a_valid), 32'(e.a_valid));
      check("cap_b_valid", 32'(b_valid), 32'(e.b_valid));
      chk_pend = 0;
    end
    if (load_done === 1'b1) begin
      ld_cnt++;
      if (exp_q.size() == 0) check("unexpected_capture", 32'd1, 32'd0);
      else chk_pend = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset with all switches high
    reset = 1'b1;
    swi   = 8'hFF;
    cyc(3);
    check("rst_stable",  32'(swi_stable), 32'h00);
    check("rst_op_a",    32'(op_a),       32'h0);
    check("rst_op_b",    32'(op_b),       32'h0);
    check("rst_valids",  32'({a_valid, b_valid}), 32'h0);
    check("rst_flags",   32'({sel_b, load_done, busy}), 32'h0);
    // Load key high at release: one capture into B (sel=1, B src=11)
    push(2'b00, 2'b11, 1'b0, 1'b1);
    reset = 1'b0;
    cyc(5);
    check("rel_stable_5", 32'(swi_stable), 32'h00);
    cyc(1);
    check("rel_stable_6", 32'(swi_stable), 32'hFF);
    cyc(5);
    check("rel_busy", 32'(busy), 32'd1);
    swi = 8'h00;
    cyc(10);
    check("rel_idle", 32'(busy), 32'd0);
    check("rel_ld_cnt", 32'(ld_cnt), 32'd1);

    // Debounce: 3-cycle glitch rejected, 6-cycle hold accepted
    swi[4] = 1'b1;
    repeat (3) @(negedge clk_2);
    swi[4] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_2);
      check("glitch_bit4", 32'(swi_stable[4]), 32'd0);
    end
    swi[4] = 1'b1;
    cyc(5);
    check("hold_bit4_5", 32'(swi_stable[4]), 32'd0);
    cyc(1);
    check("hold_bit4_6", 32'(swi_stable[4]), 32'd1);

    // Capture A = 11, B untouched
    swi = 8'b0001_1000;
    cyc(8);
    base = ld_cnt;
    push(2'b11, 2'b11, 1'b1, 1'b1);
    swi[0] = 1'b1;
    cyc(12);
    swi[0] = 1'b0;
    cyc(10);
    check("capA_pulses", 32'(ld_cnt - base), 32'd1);
    check("capA_idle",   32'(busy), 32'd0);

    // Capture B = 10 and hold the load key for 20 cycles
    swi = 8'b1100_0000;
    cyc(8);
    check("capB_sel", 32'(sel_b), 32'd1);
    base = ld_cnt;
    push(2'b11, 2'b10, 1'b1, 1'b1);
    swi[0] = 1'b1;
    cyc(20);
    check("capB_busy_hold", 32'(busy), 32'd1);
    check("capB_pulses",    32'(ld_cnt - base), 32'd1);
    swi[0] = 1'b0;
    cyc(5);
    check("capB_busy_rel5", 32'(busy), 32'd1);
    cyc(3);
    check("capB_idle", 32'(busy), 32'd0);

    // Reset while in WAIT_RELEASE with op_a = 01
    swi = 8'b0000_1000;
    cyc(8);
    push(2'b01, 2'b10, 1'b1, 1'b1);
    swi[0] = 1'b1;
    cyc(12);
    check("mid_busy",  32'(busy), 32'd1);
    check("mid_op_a",  32'(op_a), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_op_a",   32'(op_a), 32'h0);
    check("mid_rst_valids", 32'({a_valid, b_valid}), 32'h0);
    check("mid_rst_op_b",   32'(op_b), 32'h0);
    check("mid_rst_busy",   32'(busy), 32'd0);
    swi = 8'h00;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    check("post_rst_idle", 32'(busy), 32'd0);

`ifdef SWI_READER_CLEAR_EN
    // Fill both operands, then clear
    swi = 8'b0001_1000;
    cyc(8);
    push(2'b11, 2'b00, 1'b1, 1'b0);
    swi[0] = 1'b1; cyc(12); swi[0] = 1'b0; cyc(10);
    swi = 8'b1100_0000;
    cyc(8);
    push(2'b11, 2'b10, 1'b1, 1'b1);
    swi[0] = 1'b1; cyc(12); swi[0] = 1'b0; cyc(10);
    swi = 8'b0000_0010;
    cyc(10);
    check("clr_ops",    32'({op_a, op_b}), 32'h0);
    check("clr_valids", 32'({a_valid, b_valid}), 32'h0);
    swi = 8'h00;
    cyc(10);
    // Load and clear together: load wins
    push(2'b11, 2'b00, 1'b1, 1'b0);
    swi = 8'b0001_1011;
    cyc(12);
    swi = 8'h00;
    cyc(10);
    check("clr_vs_load_a", 32'(a_valid), 32'd1);
    check("clr_vs_load_b", 32'(b_valid), 32'd0);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
